audpdm2fifo: RTL and testbench
==============================

Name: audpdm2fifo

Overview:
- Capture side of the audio path: drives the on-board PDM microphone clock and samples its 1-bit data stream.
- Decimates the stream by counting ones per fixed window into unsigned DATA_WIDTH-bit PCM samples.
- Packs four samples per word and pushes words through a standard FIFO write interface toward the DMA S2MM path.
- Mirror of the FIFO-to-PWM playback block: same sample width, same packing order, same window length.

Parameters:
- DATA_WIDTH, 8, bits per PCM sample; decimation window = 2^DATA_WIDTH PDM bits.
- FIFO_DATA_WIDTH, 32, FIFO word width; must equal 4*DATA_WIDTH.
- CLK_DIV, 25, clk cycles per m_clk half-period (100 MHz -> 2 MHz m_clk).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- en  in  1  capture enable, level.
- m_clk  out  1  PDM microphone clock.
- m_data  in  1  PDM data from microphone, asynchronous to clk.
- m_lr_sel  out  1  microphone channel select, tied 0.
- fifo_wr_data  out  FIFO_DATA_WIDTH  packed samples (FIFO_WRITE WR_DATA).
- fifo_wr_en  out  1  one-cycle write strobe (FIFO_WRITE WR_EN).
- fifo_full  in  1  FIFO full flag (FIFO_WRITE FULL).
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Clocking and reset:
  - One clock domain (clk). Reset is synchronous and active-low.
  - Reset values: m_clk=0, fifo_wr_en=0, fifo_wr_data=0, overflow=0, m_lr_sel=0.
  - All counters and accumulators clear on reset; FSM returns to IDLE.
- FSM states: IDLE, RUN.
  - IDLE: m_clk held 0; div_cnt, bit_cnt, ones, and lane all held 0. Go to RUN when en=1.
  - RUN: go to IDLE on the first cycle en=0. The partial window and partial word are discarded, and m_clk is forced to 0 on the next edge.
- Clock divider (RUN):
  - div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1, m_clk toggles and div_cnt wraps to 0.
  - m_clk period = 2*CLK_DIV clk cycles, 50% duty.
- Data capture:
  - m_data passes through a 2-flop synchronizer.
  - Sample strobe fires when div_cnt==CLK_DIV-1 and m_clk==0, i.e. the last cycle before the rising edge. The synchronized bit is taken on that cycle.
- Decimation:
  - ones is a DATA_WIDTH+1 bit counter; bit_cnt is DATA_WIDTH bits.
  - On each strobe, ones += bit and bit_cnt increments.
  - On the strobe where bit_cnt wraps from 2^DATA_WIDTH-1 to 0:
    - sample = min(ones+bit, 2^DATA_WIDTH-1), i.e. saturated, so a window of all ones yields 0xFF;
    - ones resets to 0.
- Packing:
  - Each sample goes into lane lane (0..3): lane0 -> bits[7:0], lane1 -> [15:8], lane2 -> [23:16], lane3 -> [31:24].
  - lane increments per sample and wraps after 3.
- FIFO write:
  - In the cycle after lane 3 is filled, the packed word is registered onto fifo_wr_data.
  - fifo_wr_en is asserted for exactly one cycle if fifo_full==0 in that cycle.
  - If fifo_full==1, no write occurs, the word is dropped, and overflow is set.
  - fifo_wr_data holds its last value between writes.
- Overflow: overflow_clr and a simultaneous new overflow in the same cycle leave overflow=1 (set wins).
- Latency and rate:
  - Last PDM bit strobe to fifo_wr_en is 1 clk cycle.
  - Words are spaced 4*2^DATA_WIDTH*2*CLK_DIV clk cycles apart (51200 at defaults); fifo_wr_en is never asserted back-to-back.
- Reset mid-operation: asserting resetn=0 at any point overrides everything in the next cycle, including a write pending that cycle.

Decomposition:
- Shared package (audio_pkg):
  - AUD_DATA_WIDTH=8, AUD_FIFO_WIDTH=32, AUD_LANES=4;
  - PDM/PWM window length 2^AUD_DATA_WIDTH, shared with the playback block.
- One sub-module, pdm_clk_gen: divider plus m_clk generation plus sample-strobe output, with en/resetn inputs. Decimation, packing and FIFO logic stay in the top.

Test Plan:
- m_data held 1, en=1, fifo_full=0 -> first fifo_wr_en 51200 (+/- sync latency) cycles after en; fifo_wr_data=0xFFFFFFFF; m_clk period exactly 50 cycles.
- m_data held 0 -> fifo_wr_data=0x00000000; subsequent words identical; exactly one wr_en pulse per 51200 cycles.
- Bench drives m_data on m_clk falling edges: alternating 1,0 -> 0x80808080; then 3 of 4 bits high -> 0xC0C0C0C0.
- fifo_full=1 during the 2nd word's write cycle -> no wr_en, overflow=1; 3rd word written normally; overflow_clr pulse -> overflow=0.
- en dropped mid-window (after 100 bits) -> IDLE next cycle, m_clk=0, no write. en re-raised with m_data=1 -> first word is 0xFFFFFFFF, with no stale partial data.
- resetn=0 on the cycle a write is due -> fifo_wr_en stays 0, all outputs at reset values next cycle, overflow=0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the audio capture (PDM) and playback (PWM) paths.
// Both directions must agree on sample width, lane packing and window length.
package audio_pkg;

   localparam int unsigned AUD_DATA_WIDTH = 8;
   localparam int unsigned AUD_FIFO_WIDTH = 32;
   localparam int unsigned AUD_LANES      = 4;

   // PDM/PWM window length in one-bit slots; one PCM sample per window.
   localparam int unsigned AUD_WINDOW_LEN = 2 ** AUD_DATA_WIDTH;

endpackage

// File: rtl/audpdm2fifo_pdm_clk_gen.sv
// PDM microphone clock generator: divides clk down to m_clk and flags the
// last clk cycle of each m_clk low phase, where the microphone bit is taken.
module pdm_clk_gen #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   output logic m_clk,
   output logic strobe
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   // Half-period counter; m_clk toggles on wrap and is parked low when disabled.
   always_ff @(posedge clk) begin
      if (!resetn || !en) begin
         div_cnt <= '0;
         m_clk   <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         m_clk   <= ~m_clk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Last cycle before the m_clk rising edge.
   assign strobe = en && (div_cnt == DIV_LAST) && !m_clk;

endmodule

// File: rtl/audpdm2fifo.sv
// PDM capture: samples the microphone bit stream, decimates by counting ones
// per window into unsigned PCM samples, packs four samples per FIFO word.
module audpdm2fifo
   import audio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = AUD_DATA_WIDTH,
   parameter int unsigned FIFO_DATA_WIDTH = AUD_FIFO_WIDTH,
   parameter int unsigned CLK_DIV         = 25
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       en,
   output logic                       m_clk,
   input  logic                       m_data,
   output logic                       m_lr_sel,
   output logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
   output logic                       fifo_wr_en,
   input  logic                       fifo_full,
   output logic                       overflow,
   input  logic                       overflow_clr
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int unsigned LANE_W = $clog2(AUD_LANES);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(AUD_LANES - 1);

   logic [0:0]                 state;
   logic                       run;
   logic                       strobe;
   logic [1:0]                 sync_q;
   logic                       pdm_bit;
   logic [DATA_WIDTH-1:0]      bit_cnt;
   logic [DATA_WIDTH:0]        ones;
   logic [DATA_WIDTH:0]        ones_next;
   logic [DATA_WIDTH-1:0]      sample;
   logic [LANE_W-1:0]          lane;
   logic [FIFO_DATA_WIDTH-1:0] pack;
   logic [FIFO_DATA_WIDTH-1:0] pack_next;
   logic                       window_done;
   logic                       word_done;

   assign m_lr_sel = 1'b0;

   // Leaving RUN takes effect in the same cycle en drops, so no strobe can
   // land in that cycle and the partial window is discarded cleanly.
   assign run = (state == ST_RUN) && en;

   // Two-state capture FSM.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (en)  state <= ST_RUN;
            ST_RUN:  if (!en) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   pdm_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk    (clk),
      .resetn (resetn),
      .en     (run),
      .m_clk  (m_clk),
      .strobe (strobe)
   );

   // Two-flop synchronizer for the asynchronous microphone data.
   always_ff @(posedge clk) begin
      if (!resetn) sync_q <= '0;
      else         sync_q <= {sync_q[0], m_data};
   end

   assign pdm_bit = sync_q[1];

   // Window accounting, saturation and lane insertion of the finished sample.
   always_comb begin
      ones_next   = ones + {{DATA_WIDTH{1'b0}}, pdm_bit};
      sample      = ones_next[DATA_WIDTH] ? '1 : ones_next[DATA_WIDTH-1:0];
      window_done = strobe && (bit_cnt == '1);
      word_done   = window_done && (lane == LANE_LAST);
      pack_next   = pack;
      pack_next[lane*DATA_WIDTH +: DATA_WIDTH] = sample;
   end

   // Decimation counters and word packing; everything clears outside RUN.
   always_ff @(posedge clk) begin
      if (!resetn || !run) begin
         bit_cnt <= '0;
         ones    <= '0;
         lane    <= '0;
         pack    <= '0;
      end else if (strobe) begin
         bit_cnt <= bit_cnt + DATA_WIDTH'(1);
         if (window_done) begin
            ones <= '0;
            pack <= pack_next;
            lane <= (lane == LANE_LAST) ? '0 : lane + LANE_W'(1);
         end else begin
            ones <= ones_next;
         end
      end
   end

   // FIFO write strobe and data register; dropped words leave the data unchanged.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
      end else begin
         fifo_wr_en <= 1'b0;
         if (word_done && !fifo_full) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= pack_next;
         end
      end
   end

   // Sticky overflow; a new drop beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!resetn)                    overflow <= 1'b0;
      else if (word_done && fifo_full) overflow <= 1'b1;
      else if (overflow_clr)          overflow <= 1'b0;
   end

endmodule

// File: tb/tb_audpdm2fifo.sv
// Scoreboard bench for audpdm2fifo at reduced size (4-bit samples, m_clk = clk/8)
// so that every scenario completes in a few thousand cycles.
module tb_audpdm2fifo;

   localparam int DW         = 4;
   localparam int FW         = 16;
   localparam int CD         = 4;
   localparam int WIN        = 2 ** DW;
   localparam int WORD_BITS  = 4 * WIN;
   localparam int WORD_CYC   = WORD_BITS * 2 * CD;
   localparam int MCLK_PER   = 2 * CD;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          en = 1'b0;
   logic          m_data = 1'b0;
   logic          fifo_full = 1'b0;
   logic          overflow_clr = 1'b0;
   logic          m_clk;
   logic          m_lr_sel;
   logic [FW-1:0] fifo_wr_data;
   logic          fifo_wr_en;
   logic          overflow;

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            en_cyc = 0;
   int            run_id = 0;
   bit            first_due = 1'b0;
   bit            chk_spacing = 1'b1;
   logic [FW-1:0] exp_q[$];

   audpdm2fifo #(
      .DATA_WIDTH      (DW),
      .FIFO_DATA_WIDTH (FW),
      .CLK_DIV         (CD)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .en           (en),
      .m_clk        (m_clk),
      .m_data       (m_data),
      .m_lr_sel     (m_lr_sel),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_full    (fifo_full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit pat_bit(input int pat, input int k);
      case (pat)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (k % 2) == 0;
         default: return (k % 4) != 3;
      endcase
   endfunction

   function automatic logic [FW-1:0] exp_word(input int pat, input int w);
      logic [FW-1:0] wd = '0;
      for (int l = 0; l < 4; l++) begin
         int cnt = 0;
         for (int b = 0; b < WIN; b++) cnt += int'(pat_bit(pat, w * WORD_BITS + l * WIN + b));
         if (cnt > WIN - 1) cnt = WIN - 1;
         wd |= FW'(cnt) << (DW * l);
      end
      return wd;
   endfunction

   // Output monitor: scoreboard pop, write spacing, first-word latency, m_clk period.
   int   last_wr_cyc = -1;
   int   last_run = -1;
   int   last_rise = -1;
   logic prev_wen = 1'b0;
   logic prev_mclk = 1'b0;

   always @(negedge clk) begin
      if (fifo_wr_en) begin
         check_val("wr_b2b", prev_wen, 0);
         if (exp_q.size() == 0) check_val("wr_unexpected", fifo_wr_en, 0);
         else                   check_val("wr_data", fifo_wr_data, exp_q.pop_front());
         if (first_due) begin
            check_val($sformatf("first_lat_%0d", cyc - en_cyc),
                      (cyc - en_cyc) inside {[WORD_CYC - 12 : WORD_CYC + 8]}, 1);
            first_due = 1'b0;
         end
         if (chk_spacing && last_run == run_id) check_val("wr_spacing", cyc - last_wr_cyc, WORD_CYC);
         last_wr_cyc = cyc;
         last_run    = run_id;
      end
      if (resetn && en && m_clk && !prev_mclk) begin
         if (last_rise >= 0) check_val("mclk_period", cyc - last_rise, MCLK_PER);
         last_rise = cyc;
      end
      if (!en || !resetn) last_rise = -1;
      prev_wen  = fifo_wr_en;
      prev_mclk = m_clk;
   end

   task automatic wait_fall();
      logic prev;
      prev = m_clk;
      for (int i = 0; i < 4 * CD + 4; i++) begin
         @(posedge clk); #1;
         if (prev && !m_clk) return;
         prev = m_clk;
      end
      check_val("mclk_fall_timeout", 0, 1);
   endtask

   task automatic start_run(input int pat);
      @(posedge clk); #1;
      m_data    = pat_bit(pat, 0);
      en        = 1'b1;
      en_cyc    = cyc;
      run_id++;
      first_due = 1'b1;
   endtask

   task automatic stop_run();
      @(posedge clk); #1;
      en = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic drive_bits(input int pat, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         wait_fall();
         m_data = pat_bit(pat, k);
      end
   endtask

   task automatic run_word(input int pat, input int w, input bit push, input bit exp_wen);
      drive_bits(pat, (w == 0) ? 1 : w * WORD_BITS, w * WORD_BITS + WORD_BITS - 1);
      if (push) exp_q.push_back(exp_word(pat, w));
      repeat (CD) @(posedge clk);
      @(negedge clk);
      check_val("wr_latency", fifo_wr_en, exp_wen);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_mclk", m_clk, 0);
      check_val("rst_wr_en", fifo_wr_en, 0);
      check_val("rst_wr_data", fifo_wr_data, 0);
      check_val("rst_overflow", overflow, 0);
      check_val("rst_lr_sel", m_lr_sel, 0);
      @(posedge clk); #1 resetn = 1'b1;

      // All ones: saturated samples.
      start_run(1);
      run_word(1, 0, 1'b1, 1'b1);
      run_word(1, 1, 1'b1, 1'b1);
      stop_run();

      // All zeros.
      start_run(0);
      for (int w = 0; w < 3; w++) run_word(0, w, 1'b1, 1'b1);
      stop_run();

      // Alternating, then three of four high.
      start_run(2);
      for (int w = 0; w < 2; w++) run_word(2, w, 1'b1, 1'b1);
      stop_run();
      start_run(3);
      for (int w = 0; w < 2; w++) run_word(3, w, 1'b1, 1'b1);
      stop_run();

      // Overflow: second word dropped while a clear is held (set wins).
      chk_spacing = 1'b0;
      start_run(3);
      run_word(3, 0, 1'b1, 1'b1);
      fifo_full = 1'b1;
      overflow_clr = 1'b1;
      run_word(3, 1, 1'b0, 1'b0);
      check_val("ovf_set", overflow, 1);
      fifo_full = 1'b0;
      overflow_clr = 1'b0;
      run_word(3, 2, 1'b1, 1'b1);
      check_val("ovf_sticky", overflow, 1);
      @(posedge clk); #1 overflow_clr = 1'b1;
      @(posedge clk); #1 overflow_clr = 1'b0;
      @(negedge clk);
      check_val("ovf_clr", overflow, 0);
      stop_run();
      chk_spacing = 1'b1;

      // en dropped mid-word while m_clk is high, then a clean restart.
      start_run(1);
      drive_bits(1, 1, 40);
      for (int i = 0; i < 2 * CD + 2; i++) begin
         @(posedge clk); #1;
         if (m_clk) break;
      end
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("drop_mclk", m_clk, 0);
      check_val("drop_wr_en", fifo_wr_en, 0);
      repeat (20) @(posedge clk);
      start_run(2);
      run_word(2, 0, 1'b1, 1'b1);
      stop_run();

      // Reset landing on the strobe that would complete a word.
      start_run(1);
      first_due = 1'b0;
      fifo_full = 1'b1;
      run_word(1, 0, 1'b0, 1'b0);
      check_val("pre_rst_ovf", overflow, 1);
      fifo_full = 1'b0;
      drive_bits(1, WORD_BITS, 2 * WORD_BITS - 1);
      repeat (CD - 1) @(posedge clk);
      #1;
      resetn = 1'b0;
      en     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("midrst_wr_en", fifo_wr_en, 0);
      check_val("midrst_wr_data", fifo_wr_data, 0);
      check_val("midrst_overflow", overflow, 0);
      check_val("midrst_mclk", m_clk, 0);
      check_val("midrst_lr_sel", m_lr_sel, 0);
      @(posedge clk); #1 resetn = 1'b1;
      repeat (2 * WORD_CYC / 64) @(posedge clk);

      check_val("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
